clock_divider_multi: RTL and testbench
======================================

# clock_divider_multi

Parametrised, multi-channel successor to the single-output divider. Generates NUM_CH independent divided clocks from one fabric clock, each with runtime-programmable period and high time (arbitrary duty), a one-cycle period-start strobe, per-channel enable, glitch-free reconfiguration at period boundaries, and a global sync that phase-aligns all channels. Feeds audio/ADC sample timing, display refresh and sensor-poll enables in the HeartAware top level.

## Interface
Parameters:
- NUM_CH, 4: number of independent channels (1..16)
- CNT_W, 32: counter/config width; period max 2^CNT_W − 1

Ports:
- clk_in  input  1  fabric clock (100 MHz on board)
- reset_n  input  1  asynchronous, active-low reset
- enable  input  NUM_CH  per-channel run enable, level
- period  input  NUM_CH*CNT_W  channel i at [i*CNT_W +: CNT_W]; input cycles per output period P
- high_count  input  NUM_CH*CNT_W  same packing; cycles output is high per period H
- sync  input  1  restart all enabled channels at phase 0
- clk_out  output  NUM_CH  divided clocks (registered)
- tick  output  NUM_CH  one-cycle pulse at each period start
- active  output  NUM_CH  channel running with a valid configuration

## Operation
- Per channel: counter cnt, shadow registers P_s, H_s, state IDLE/RUN.
- Config is sampled only on start, wrap or sync; mid-period input changes have no effect until the next boundary.
- Valid config: P ≥ 2. P ∈ {0,1} at a load point → channel goes or stays IDLE.
- IDLE → RUN: enable=1 and valid period. Start action: cnt←0, P_s←period, H_s←high_count, tick←1, clk_out←(high_count≠0), active←1.
- RUN, cnt < P_s−1: cnt←cnt+1, clk_out←(cnt+1 < H_s), tick←0.
- RUN, cnt = P_s−1 (wrap): perform start action with current inputs; if new period invalid → IDLE.
- Duty: H=0 → constant low (ticks still emitted); H ≥ P → constant high; otherwise high for cycles 0..H−1 of each period.
- enable=0 sampled in any state → IDLE immediately: cnt←0, clk_out←0, tick←0, active←0. Abrupt stop; no period completion.
- sync=1: every channel with enable=1 performs the start action on that edge (IDLE channels with valid config start too). Priority: reset > enable=0 > sync > wrap > count.
- Legacy equivalence: old divider value D equals P=2D, H=D.
- Comparisons unsigned, CNT_W bits; cnt+1 never overflows because cnt < P_s ≤ 2^CNT_W−1.

## Timing
- Reset (async assert, sync release in use): cnt, P_s, H_s, clk_out, tick, active all 0; all channels IDLE.
- All outputs registered; no combinational path input→output.
- Start latency: enable sampled high at edge k → clk_out, tick, active valid after edge k.
- tick high exactly one cycle, coincident with the first cycle of each period (rising edge of clk_out when H≠0).
- Output period exactly P_s cycles; high phase exactly min(H_s, P_s) cycles.
- sync and wrap on same edge → single start action, single tick.
- Back-to-back sync every cycle: channel held at cnt=0, tick high continuously.
- Reset mid-period: outputs drop to 0 asynchronously; after release channels restart only via enable sampling.

## Structure
- Shared package clock_divider_pkg: CNT_W default, state encoding (ST_IDLE, ST_RUN), MAX_CH constant, helper to compute P/H from target frequency (documentation constant).
- One sub-module: divider_channel (single channel counter, shadow config, FSM); clock_divider_multi instantiates NUM_CH via generate and fans out sync.

## Test plan
- P=4, H=2, enable at cycle 10 → clk_out 1100 repeating, tick at cycles 10,14,18; active=1 from cycle 10.
- P=5, H=2 then period→3, H→1 written mid-period at cnt=2 → current period finishes 11000, next is 100, tick spacing 5 then 3.
- H=0 and H=7 with P=4 → constant low / constant high, tick every 4 cycles; P=1 → active stays 0, clk_out 0.
- Channel 0 P=6, channel 1 P=4, free-running; sync at cycle 50 → both tick at cycle 50, cnt=0 both; coincident wrap+sync yields one tick.
- Deassert reset_n while clk_out=1 at cnt=3 → all outputs 0 immediately; disable via enable=0 at cnt=2 → outputs 0 next edge, re-enable restarts at phase 0.
- NUM_CH=1, P=3126, H=1563 at 100 MHz → 31.99 kHz, 50% duty, matches legacy divider=1563 output.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg: shared types and constants for the multi-channel clock divider.
package clock_divider_pkg;
    localparam int CNT_W_DEF = 32;
    localparam int MAX_CH = 16;
    typedef enum logic {ST_IDLE, ST_RUN} ch_state_t;
    // nearest period for a target output frequency; high time for 50% duty is half of this
    function automatic int unsigned period_for(input int unsigned f_clk, input int unsigned f_out);
        return (f_clk + f_out / 2) / f_out;
    endfunction
endpackage

// File: rtl/clock_divider_multi_if.sv
// clock_divider_multi_if: per-channel control inputs and divided-clock outputs.
interface clock_divider_multi_if #(parameter int NUM_CH = 4, parameter int CNT_W = 32);
    logic [NUM_CH-1:0]       enable;
    logic [NUM_CH*CNT_W-1:0] period;
    logic [NUM_CH*CNT_W-1:0] high_count;
    logic                    sync;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       active;
    modport master (output enable, period, high_count, sync, input clk_out, tick, active);
    modport slave (input enable, period, high_count, sync, output clk_out, tick, active);
endinterface

// File: rtl/divider_channel.sv
// divider_channel: one programmable-period, programmable-duty divided clock with shadowed config.
module divider_channel
    import clock_divider_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sync,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] high_count,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);
    ch_state_t        state;
    logic [CNT_W-1:0] cnt, p_s, h_s;
    logic             load, valid;
    logic [CNT_W-1:0] cnt_nxt;

    // config is only taken at a start, wrap or sync so mid-period writes never glitch the output
    assign load    = sync || state == ST_IDLE || cnt == p_s - CNT_W'(1);
    assign valid   = period >= CNT_W'(2);
    assign cnt_nxt = cnt + CNT_W'(1);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            p_s     <= '0;
            h_s     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            active  <= 1'b0;
        end else if (!enable || (load && !valid)) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
            active  <= 1'b0;
        end else if (load) begin
            state   <= ST_RUN;
            cnt     <= '0;
            p_s     <= period;
            h_s     <= high_count;
            clk_out <= high_count != '0;
            tick    <= 1'b1;
            active  <= 1'b1;
        end else begin
            cnt     <= cnt_nxt;
            clk_out <= cnt_nxt < h_s;
            tick    <= 1'b0;
        end
    end
endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH independent divided clocks sharing one fabric clock and a global sync.
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk_in,
    input  logic                  reset_n,
    clock_divider_multi_if.slave  bus
);
    logic [NUM_CH-1:0] clk_out_v, tick_v, active_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        divider_channel #(.CNT_W(CNT_W)) u_ch (
            .clk_in     (clk_in),
            .reset_n    (reset_n),
            .enable     (bus.enable[i]),
            .sync       (bus.sync),
            .period     (bus.period[i*CNT_W +: CNT_W]),
            .high_count (bus.high_count[i*CNT_W +: CNT_W]),
            .clk_out    (clk_out_v[i]),
            .tick       (tick_v[i]),
            .active     (active_v[i])
        );
    end

    assign bus.clk_out = clk_out_v;
    assign bus.tick    = tick_v;
    assign bus.active  = active_v;
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: scoreboard bench comparing every output cycle against a phase model.
module tb_clock_divider_multi;
    localparam int NUM_CH = 2;
    localparam int CNT_W  = 32;

    typedef struct packed {
        logic [NUM_CH-1:0] o;
        logic [NUM_CH-1:0] t;
        logic [NUM_CH-1:0] a;
    } exp_t;

    logic clk_in = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   hi_cnt, tick_cnt;
    exp_t sb_q[$];

    logic [CNT_W-1:0] m_cnt [NUM_CH];
    logic [CNT_W-1:0] m_p   [NUM_CH];
    logic [CNT_W-1:0] m_h   [NUM_CH];
    logic             m_run [NUM_CH];

    clock_divider_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clock_divider_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_ch(input int c, input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] h);
        bus.period[c*CNT_W +: CNT_W]     = p;
        bus.high_count[c*CNT_W +: CNT_W] = h;
    endtask

    // model predicts the edge about to happen from the inputs now applied, then the DUT is compared
    task automatic cycle();
        exp_t e;
        exp_t g;
        logic [CNT_W-1:0] p, h;
        e = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            p = bus.period[c*CNT_W +: CNT_W];
            h = bus.high_count[c*CNT_W +: CNT_W];
            if (!reset_n || !bus.enable[c]) begin
                m_run[c] = 1'b0;
                m_cnt[c] = '0;
            end else if (bus.sync || !m_run[c] || m_cnt[c] == m_p[c] - 1) begin
                m_run[c] = p >= 2;
                m_cnt[c] = '0;
                e.t[c]   = p >= 2;
                if (p >= 2) begin
                    m_p[c] = p;
                    m_h[c] = h;
                end
            end else begin
                m_cnt[c] = m_cnt[c] + 1;
            end
            e.a[c] = m_run[c];
            e.o[c] = m_run[c] && m_cnt[c] < m_h[c];
        end
        sb_q.push_back(e);
        @(posedge clk_in);
        #1;
        e = sb_q.pop_front();
        g.o = bus.clk_out;
        g.t = bus.tick;
        g.a = bus.active;
        chk("clk_out", 64'(g.o), 64'(e.o));
        chk("tick", 64'(g.t), 64'(e.t));
        chk("active", 64'(g.a), 64'(e.a));
        hi_cnt   += int'(g.o[0]);
        tick_cnt += int'(g.t[0]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        bus.enable = '0;
        bus.sync   = 1'b0;
        bus.period = '0;
        bus.high_count = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = '0; m_p[c] = '0; m_h[c] = '0; m_run[c] = 1'b0;
        end
        run(3);
        chk("reset_outs", 64'({bus.clk_out, bus.tick, bus.active}), 64'd0);
        reset_n = 1'b1;
        run(6);

        // basic 50% duty, then a mid-period reconfiguration on the other channel
        set_ch(0, 4, 2);
        bus.enable[0] = 1'b1;
        run(12);
        set_ch(1, 5, 2);
        bus.enable[1] = 1'b1;
        run(3);
        set_ch(1, 3, 1);
        run(12);

        // duty extremes and an invalid period
        bus.enable = '0;
        run(2);
        set_ch(0, 4, 0);
        bus.enable[0] = 1'b1;
        run(9);
        set_ch(0, 4, 7);
        run(9);
        bus.enable[0] = 1'b0;
        run(1);
        set_ch(0, 1, 1);
        bus.enable[0] = 1'b1;
        run(6);
        chk("p1_idle", 64'(bus.active[0]), 64'd0);

        // free-running pair, global sync, sync on a wrap edge, back-to-back sync
        set_ch(0, 6, 3);
        set_ch(1, 4, 2);
        bus.enable = 2'b11;
        run(23);
        bus.sync = 1'b1;
        run(1);
        chk("sync_tick", 64'(bus.tick), 64'h3);
        bus.sync = 1'b0;
        run(4);
        for (int i = 0; i < 10 && m_cnt[0] != m_p[0] - 1; i++) run(1);
        bus.sync = 1'b1;
        run(1);
        bus.sync = 1'b0;
        run(3);
        bus.sync = 1'b1;
        run(5);
        chk("sync_hold", 64'(bus.tick), 64'h3);
        bus.sync = 1'b0;
        run(8);

        // abrupt disable at cnt=2, then re-enable restarts at phase 0
        for (int i = 0; i < 10 && m_cnt[0] != 2; i++) run(1);
        bus.enable[0] = 1'b0;
        run(2);
        bus.enable[0] = 1'b1;
        run(8);

        // async reset while clk_out is high at cnt=3
        set_ch(0, 6, 5);
        run(7);
        for (int i = 0; i < 10 && m_cnt[0] != 3; i++) run(1);
        chk("pre_rst_hi", 64'(bus.clk_out[0]), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async", 64'({bus.clk_out, bus.tick, bus.active}), 64'd0);
        bus.enable = '0;
        run(2);
        reset_n = 1'b1;
        run(3);

        // legacy divider 1563 equivalence: 3126-cycle period, 1563 cycles high
        set_ch(0, 3126, 1563);
        bus.enable[0] = 1'b1;
        hi_cnt = 0;
        tick_cnt = 0;
        run(3126);
        chk("legacy_high", 64'(hi_cnt), 64'd1563);
        chk("legacy_ticks", 64'(tick_cnt), 64'd1);
        run(1);
        chk("legacy_wrap", 64'(bus.tick[0]), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
